// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Included by bin2bcd_seq and bcd_adj; BCD_BLANK is only read in the BIN2BCD_BLANK_EN build.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef logic [3:0] nibble_t;

   localparam nibble_t BCD_BLANK      = 4'hF;
   localparam nibble_t BCD_ADJ_THRESH = 4'd5;

endpackage

// File: rtl/bcd_adj.sv
// Double-dabble digit correction: add 3 to a BCD nibble holding 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_adj
   import bcd_pkg::*;
(
   input  nibble_t nib_i,
   output nibble_t nib_o
);

   assign nib_o = (nib_i >= BCD_ADJ_THRESH) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per cycle).
// Define BIN2BCD_BLANK_EN to blank leading-zero digits (4'hF) in the result.
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int IN_W   = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_W-1:0]       in_bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd_out
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(IN_W + 1);

   localparam logic [63:0] DEC_RANGE = 64'(10) ** DIGITS;
   localparam logic [63:0] BIN_MAX   = (64'(1) << IN_W) - 64'd1;

   if (DEC_RANGE <= BIN_MAX) begin : g_range_check
      $error("bin2bcd_seq: DIGITS too small to hold 2**IN_W-1");
   end

   state_t            state_q;
   logic [BW-1:0]     acc_q;
   logic [IN_W-1:0]   opd_q;
   logic [CW-1:0]     cnt_q;
   logic [BW-1:0]     bcd_q;
   logic              in_ready_q;
   logic              out_valid_q;

   logic [BW-1:0]     acc_adj;
   logic [BW-1:0]     acc_shift_d;
   logic [BW-1:0]     result_d;
   logic              unused_msb;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_adj u_adj (
         .nib_i (acc_q[4*g +: 4]),
         .nib_o (acc_adj[4*g +: 4])
      );
   end

   // The adjusted top bit is always 0 for in-range operands, so it is shifted out.
   assign acc_shift_d = {acc_adj[BW-2:0], opd_q[IN_W-1]};
   assign unused_msb  = acc_adj[BW-1];

`ifdef BIN2BCD_BLANK_EN
   logic lead_zero;

   always_comb begin
      result_d  = acc_shift_d;
      lead_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (lead_zero && (acc_shift_d[4*i +: 4] == 4'd0)) begin
            result_d[4*i +: 4] = BCD_BLANK;
         end else begin
            lead_zero = 1'b0;
         end
      end
   end
`else
   assign result_d = acc_shift_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         opd_q       <= '0;
         cnt_q       <= '0;
         bcd_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  opd_q      <= in_bin;
                  acc_q      <= '0;
                  cnt_q      <= CW'(IN_W);
                  in_ready_q <= 1'b0;
                  state_q    <= SHIFT;
               end
            end
            SHIFT: begin
               acc_q <= acc_shift_d;
               opd_q <= opd_q << 1;
               cnt_q <= cnt_q - CW'(1);
               // Result is captured on the edge of the final shift so bcd_out is registered.
               if (cnt_q == CW'(1)) begin
                  bcd_q       <= result_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign bcd_out   = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed plus randomized bench for bin2bcd_seq against a decimal-arithmetic model.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
module tb_bin2bcd_seq;

   localparam int IN_W   = 8;
   localparam int DIGITS = 3;
   localparam int BW     = 4 * DIGITS;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [IN_W-1:0] in_bin;
   logic            out_valid;
   logic            out_ready;
   logic [BW-1:0]   bcd_out;

   int vectors;
   int fails;
   logic [BW-1:0] exp_q[$];

   bin2bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bin    (in_bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bcd_out   (bcd_out)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference: plain decimal digit extraction
   function automatic logic [BW-1:0] ref_bcd(input int v);
      int digit[DIGITS];
      int rem;
      logic [BW-1:0] r;
      bit lead;
      rem = v;
      for (int d = 0; d < DIGITS; d++) begin
         digit[d] = rem % 10;
         rem      = rem / 10;
      end
`ifdef BIN2BCD_BLANK_EN
      lead = 1'b1;
      for (int d = DIGITS - 1; d >= 1; d--) begin
         if (lead && digit[d] == 0) digit[d] = 15;
         else lead = 1'b0;
      end
`else
      lead = 1'b0;
`endif
      r = '0;
      for (int d = 0; d < DIGITS; d++) r[4*d +: 4] = 4'(digit[d]);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Driver: called at posedge+1 with the DUT idle. noise drives a foreign
   // operand with in_valid high throughout the conversion.
   task automatic convert(input int v, input int stall, input bit noise);
      int lat;
      logic [BW-1:0] exp;
      exp_q.push_back(ref_bcd(v));
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_bin   = IN_W'(v);
      @(posedge clk); #1;
      if (noise) begin
         in_valid = 1'b1;
         in_bin   = IN_W'(77);
      end else begin
         in_valid = 1'b0;
         in_bin   = IN_W'($urandom);
      end
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      // lat counts the edge after the accept at which out_valid is first seen
      chk("latency", 32'(lat - 1), 32'(IN_W));
      exp = exp_q.pop_front();
      chk("bcd", 32'(bcd_out), 32'(exp));
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         chk("hold_bcd", 32'(bcd_out), 32'(exp));
         chk("hold_valid", 32'(out_valid), 32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_ready", 32'(in_ready), 32'd1);
      chk("release_valid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      vectors   = 0;
      fails     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_bin    = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_bcd", 32'(bcd_out), 32'd0);
      rst_n = 1'b1;

      // first accept right on the first edge after release
      convert(255, 0, 1'b0);
      convert(0, 0, 1'b0);
      convert(9, 1, 1'b0);
      convert(40, 0, 1'b0);
      convert(128, 5, 1'b0);
      convert(200, 2, 1'b1);
      // after the noisy run, the idle cycle must not have accepted 77
      @(posedge clk); #1;
      chk("no_stray_accept", 32'(out_valid), 32'd0);
      chk("idle_after_noise", 32'(in_ready), 32'd1);

      // reset in the middle of a conversion
      in_valid = 1'b1;
      in_bin   = IN_W'(150);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_bcd", 32'(bcd_out), 32'd0);
      chk("abort_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      convert(99, 0, 1'b0);

      // randomized spot checks
      for (int i = 0; i < 20; i++)
         convert(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));

      // full sweep with random stalls
      for (int v = 0; v < 256; v++)
         convert(v, int'($urandom_range(0, 2)), 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter IN_W, default 8: binary input width.
REQ-002 SHALL have parameter DIGITS, default 3: BCD output digit count; elaboration SHALL fail unless 10**DIGITS > 2**IN_W - 1.
REQ-003 SHALL have port clk  in  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  in  1: in_bin is valid.
REQ-006 SHALL have port in_ready  out  1: block accepts a new operand.
REQ-007 SHALL have port in_bin  in  IN_W: unsigned binary operand.
REQ-008 SHALL have port out_valid  out  1: bcd_out holds a finished result.
REQ-009 SHALL have port out_ready  in  1: consumer (7-segment decoder stage) takes the result.
REQ-010 SHALL have port bcd_out  out  4*DIGITS: packed BCD digits; [3:0] is ones; each nibble feeds one bcd7seg instance.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-013 On in_valid && in_ready, SHALL latch in_bin, clear the BCD accumulator, load the shift counter with IN_W, and enter SHIFT.
REQ-014 In SHIFT, each cycle SHALL add 3 to every accumulator nibble >= 5, then shift {accumulator, operand} left by one bit (double-dabble).
REQ-015 SHALL decrement the counter once per SHIFT cycle and enter DONE when the last shift completes.
REQ-016 out_valid SHALL rise exactly IN_W rising edges after the accepting edge (8 cycles at default).
REQ-017 In DONE, bcd_out SHALL stay stable while out_ready is 0.
REQ-018 On out_valid && out_ready, SHALL return to IDLE; in_ready SHALL rise on the next cycle, with no same-cycle accept.
REQ-019 SHALL ignore in_valid and in_bin while in SHIFT or DONE; the operand SHALL NOT change mid-conversion.
REQ-020 SHALL NOT truncate any value in 0..2**IN_W-1; every output nibble SHALL be in 0..9, except as stated in REQ-025.
REQ-021 bcd_out SHALL be a registered output with no combinational path from inputs.

Reset
REQ-022 While rst_n is 0, SHALL force: state IDLE, in_ready 1, out_valid 0, bcd_out all zero, counter 0.
REQ-023 Reset asserted during SHIFT or DONE SHALL abort the conversion and discard the result; no out_valid pulse SHALL follow reset release.
REQ-024 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-025 With macro BIN2BCD_BLANK_EN defined, SHALL suppress leading zeros in DONE: each leading-zero nibble above ones SHALL read 4'hF, so the downstream decoder shows a blank segment. The ones digit is never blanked.
REQ-026 Without BIN2BCD_BLANK_EN, SHALL emit plain BCD with leading zeros; no blanking logic is present.

Structure
REQ-027 Shared package bcd_pkg SHALL hold:
- the FSM state typedef (IDLE/SHIFT/DONE);
- the nibble typedef (logic [3:0]);
- constant BCD_BLANK = 4'hF;
- constant BCD_ADJ_THRESH = 5.
REQ-028 SHALL instantiate one combinational sub-module, bcd_adj, DIGITS times: a nibble-wise add-3-if-≥5 correction.

Verification
REQ-029 Reset, then in_bin=255 accepted at edge T -> out_valid at T+8, bcd_out=12'h255.
REQ-030 in_bin=0, no macro -> bcd_out=12'h000; with BIN2BCD_BLANK_EN -> 12'hFF0. in_bin=9 with macro -> 12'hFF9. in_bin=40 with macro -> 12'hF40.
REQ-031 Backpressure: result 12'h128 (in_bin=128) held 5 cycles with out_ready=0 -> bcd_out unchanged, out_valid stays 1; then out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-032 in_valid=1 with in_bin=77 asserted during SHIFT of in_bin=200 -> result 12'h200; 77 is not converted.
REQ-033 rst_n pulsed low at cycle 4 of SHIFT -> out_valid=0, bcd_out=0, in_ready=1 immediately; the next operand 99 converts to 12'h099 after 8 cycles.
REQ-034 Exhaustive sweep 0..255 with random out_ready stalls -> every result matches a reference decimal conversion.
